// File: rtl/output_argmax.sv
// Sequential argmax over a registered vector of NUM_N signed neuron values, one element per cycle.
// Define ARGMAX_MAX_OUT_EN to add the out_max port carrying the winning value.
module output_argmax #(
  parameter int unsigned NUM_N = 10,
  parameter int unsigned WIDTH = 32,
  parameter int unsigned IDX_W = 4
) (
  input  logic                   clock,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WIDTH*NUM_N-1:0] in_neurons,
  output logic                   out_valid,
  input  logic                   out_ready,
`ifdef ARGMAX_MAX_OUT_EN
  output logic [WIDTH-1:0]       out_max,
`endif
  output logic [IDX_W-1:0]       out_index
);

  localparam logic [IDX_W-1:0] LastIdx = IDX_W'(NUM_N - 1);

  typedef enum logic [1:0] {
    StIdle,
    StScan,
    StHold
  } state_e;

  state_e                          state_q, state_d;
  logic [NUM_N-1:0][WIDTH-1:0]     vec_q, vec_d;
  logic signed [WIDTH-1:0]         best_val_q, best_val_d;
  logic [IDX_W-1:0]                best_idx_q, best_idx_d;
  logic [IDX_W-1:0]                ptr_q, ptr_d;
  logic                            out_valid_q, out_valid_d;
  logic [IDX_W-1:0]                out_index_q, out_index_d;
  logic signed [WIDTH-1:0]         elem;
  logic                            greater;
`ifdef ARGMAX_MAX_OUT_EN
  logic [WIDTH-1:0]                out_max_q, out_max_d;
`endif

  assign elem    = vec_q[ptr_q];
  // Strictly greater only, so ties keep the earlier (lower) index.
  assign greater = elem > best_val_q;

  always_comb begin
    state_d     = state_q;
    vec_d       = vec_q;
    best_val_d  = best_val_q;
    best_idx_d  = best_idx_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_index_d = out_index_q;
`ifdef ARGMAX_MAX_OUT_EN
    out_max_d   = out_max_q;
`endif
    case (state_q)
      StIdle: begin
        if (in_valid) begin
          vec_d      = in_neurons;
          best_val_d = in_neurons[WIDTH-1:0];
          best_idx_d = '0;
          ptr_d      = IDX_W'(1);
          state_d    = StScan;
        end
      end
      StScan: begin
        if (greater) begin
          best_val_d = elem;
          best_idx_d = ptr_q;
        end
        ptr_d = ptr_q + IDX_W'(1);
        if (ptr_q == LastIdx) begin
          state_d     = StHold;
          out_valid_d = 1'b1;
          out_index_d = best_idx_d;
`ifdef ARGMAX_MAX_OUT_EN
          out_max_d   = best_val_d;
`endif
        end
      end
      StHold: begin
        if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= StIdle;
      vec_q       <= '0;
      best_val_q  <= '0;
      best_idx_q  <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_index_q <= '0;
    end else begin
      state_q     <= state_d;
      vec_q       <= vec_d;
      best_val_q  <= best_val_d;
      best_idx_q  <= best_idx_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_index_q <= out_index_d;
    end
  end

`ifdef ARGMAX_MAX_OUT_EN
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      out_max_q <= '0;
    end else begin
      out_max_q <= out_max_d;
    end
  end

  assign out_max = out_max_q;
`endif

  assign in_ready  = (state_q == StIdle);
  assign out_valid = out_valid_q;
  assign out_index = out_index_q;

endmodule
